// File: rtl/universal_shift_sequencer.sv
// Multi-mode shift register with a start/busy/done command handshake.
// LOAD and degenerate commands finish in one edge; shift ops run one step per edge.
module universal_shift_sequencer #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [2:0]    op_i,
  input  logic [CW-1:0] count_i,
  input  logic [W-1:0]  load_data_i,
  input  logic          sin_r_i,
  input  logic          sin_l_i,
  output logic [W-1:0]  q_o,
  output logic          sout_r_o,
  output logic          sout_l_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [2:0]    OP_LOAD = 3'b000;
  localparam logic [2:0]    OP_SHR  = 3'b001;
  localparam logic [2:0]    OP_SHL  = 3'b010;
  localparam logic [2:0]    OP_ROR  = 3'b011;
  localparam logic [2:0]    OP_ROL  = 3'b100;
  localparam logic [2:0]    OP_ASR  = 3'b101;
  localparam logic [CW-1:0] REM_ONE = CW'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [W-1:0]  data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          is_shift_s;

  function automatic logic [W-1:0] step_f(input logic [2:0] op, input logic [W-1:0] v,
                                          input logic sr, input logic sl);
    logic [W-1:0] r;
    case (op)
      OP_SHR:  r = {sr, v[W-1:1]};
      OP_SHL:  r = {v[W-2:0], sl};
      OP_ROR:  r = {v[0], v[W-1:1]};
      OP_ROL:  r = {v[W-2:0], v[W-1]};
      OP_ASR:  r = {v[W-1], v[W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign is_shift_s = (op_i >= OP_SHR) && (op_i <= OP_ASR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      rem_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && is_shift_s && (count_i != '0)) state_d = ST_SHIFT;
        else                                          state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (rem_q == REM_ONE) state_d = ST_IDLE;
        else                  state_d = ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reserved ops and zero-count shifts complete immediately with q untouched.
  always_comb begin
    op_d   = op_q;
    rem_d  = rem_q;
    data_d = data_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (op_i == OP_LOAD) begin
            data_d = load_data_i;
            done_d = 1'b1;
          end else if (is_shift_s && (count_i != '0)) begin
            op_d   = op_i;
            rem_d  = count_i;
            busy_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        data_d = step_f(op_q, data_q, sin_r_i, sin_l_i);
        rem_d  = rem_q - REM_ONE;
        if (rem_q == REM_ONE) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          done_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign q_o      = data_q;
  assign sout_r_o = data_q[0];
  assign sout_l_o = data_q[W-1];
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_universal_shift_sequencer.sv
// Self-checking bench: directed scenarios with literal results plus random
// traffic, all compared every cycle against an arithmetic reference model.
module tb_universal_shift_sequencer;
  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst, start, sin_r, sin_l;
  logic [2:0]    op;
  logic [CW-1:0] count;
  logic [W-1:0]  load_data;
  logic [W-1:0]  q;
  logic          sout_r, sout_l, busy, done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [W-1:0] m_q;
  bit           m_busy, m_done;
  int           m_op, m_left;

  universal_shift_sequencer #(.W(W), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .count_i(count),
    .load_data_i(load_data), .sin_r_i(sin_r), .sin_l_i(sin_l),
    .q_o(q), .sout_r_o(sout_r), .sout_l_o(sout_l), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_step(input int o, input logic [W-1:0] v,
                                          input logic sr, input logic sl);
    logic [W-1:0] r;
    case (o)
      1: r = (v >> 1) | (W'(sr) << (W - 1));
      2: r = (v << 1) | W'(sl);
      3: r = (v >> 1) | (v << (W - 1));
      4: r = (v << 1) | (v >> (W - 1));
      5: r = W'($signed(v) >>> 1);
      default: r = v;
    endcase
    return r;
  endfunction

  // Model: a command of N steps keeps the block busy N cycles, then done for one.
  always @(posedge clk) begin
    if (rst) begin
      m_q = '0; m_busy = 0; m_done = 0; m_left = 0; m_op = 0;
    end else if (m_busy) begin
      m_q    = m_step(m_op, m_q, sin_r, sin_l);
      m_left = m_left - 1;
      m_busy = (m_left != 0);
      m_done = (m_left == 0);
    end else begin
      m_done = 0;
      if (start) begin
        if (op == 3'd0) begin
          m_q = load_data; m_done = 1;
        end else if (op <= 3'd5 && count != 0) begin
          m_busy = 1; m_op = int'(op); m_left = int'(count);
        end else begin
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("q", 32'(q), 32'(m_q));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("sout_r", 32'(sout_r), 32'(m_q[0]));
      check("sout_l", 32'(sout_l), 32'(m_q[W-1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] o, input int n, input logic [W-1:0] d,
                         output int busy_cyc);
    int k;
    op = o; count = CW'(n); load_data = d; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; busy_cyc = 0;
    while (!done && k < 40) begin
      if (busy) busy_cyc++;
      tick();
      k++;
    end
    if (k >= 40) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int bc;
    int k;
    rst = 1'b1; start = 1'b0; op = 3'd0; count = '0; load_data = '0;
    sin_r = 1'b0; sin_l = 1'b0;
    tick(); tick();
    check("reset_q", 32'(q), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // LOAD
    run_cmd(3'd0, 0, 8'hA5, bc);
    check("load_q", 32'(q), 32'hA5);
    check("load_busy_cycles", 32'(bc), 32'd0);
    tick();
    check("load_done_width", 32'(done), 32'd0);

    // SHR 3 with fill 1
    sin_r = 1'b1;
    run_cmd(3'd1, 3, 8'h00, bc);
    check("shr3_q", 32'(q), 32'hF4);
    check("shr3_busy_cycles", 32'(bc), 32'd3);
    check("shr3_busy_fell", 32'(busy), 32'd0);
    tick();
    check("shr3_done_width", 32'(done), 32'd0);

    // ROL 9 and ASR 10
    run_cmd(3'd0, 0, 8'h81, bc);
    run_cmd(3'd4, 9, 8'h00, bc);
    check("rol9_q", 32'(q), 32'h03);
    check("rol9_busy_cycles", 32'(bc), 32'd9);
    run_cmd(3'd0, 0, 8'h80, bc);
    run_cmd(3'd5, 10, 8'h00, bc);
    check("asr10_q", 32'(q), 32'hFF);

    // Starts held through a ROR 4, then a LOAD launched on the done cycle
    run_cmd(3'd0, 0, 8'h96, bc);
    op = 3'd3; count = CW'(4); start = 1'b1;
    tick();
    k = 0;
    while (!done && k < 20) begin
      op = 3'($urandom_range(0, 7)); count = CW'($urandom_range(0, 15));
      load_data = 8'($urandom);
      tick();
      k++;
    end
    check("ror4_q", 32'(q), 32'h69);
    check("ror4_extra_starts_ignored", 32'(k), 32'd4);
    op = 3'd0; load_data = 8'h3C;
    tick();
    start = 1'b0;
    check("b2b_load_q", 32'(q), 32'h3C);
    check("b2b_load_done", 32'(done), 32'd1);

    // Reset mid SHL 5 after two steps
    op = 3'd2; count = CW'(5); sin_l = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("shl_mid_q", 32'(q), 32'hF3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_q", 32'(q), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) k++;
      tick();
    end
    check("abort_no_done", 32'(k), 32'd0);

    // Degenerate commands
    run_cmd(3'd0, 0, 8'h5A, bc);
    run_cmd(3'd2, 0, 8'h00, bc);
    check("shl0_q", 32'(q), 32'h5A);
    check("shl0_busy_cycles", 32'(bc), 32'd0);
    run_cmd(3'd7, 5, 8'h11, bc);
    check("rsvd_q", 32'(q), 32'h5A);
    check("rsvd_busy_cycles", 32'(bc), 32'd0);
    tick();
    check("rsvd_done_width", 32'(done), 32'd0);

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      start     = ($urandom_range(0, 2) == 0);
      op        = 3'($urandom_range(0, 7));
      count     = CW'($urandom_range(0, 15));
      load_data = 8'($urandom);
      sin_r     = 1'($urandom);
      sin_l     = 1'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
